// File: rtl/cpu_mem_ctrl.sv
// Unified single-port instruction/data memory controller with strobe-less request detection
// (address changes and write-enable rising edges) and a registered mirror of one display word.
module cpu_mem_ctrl #(
    parameter int DEPTH     = 32,
    parameter int IDX_W     = 5,
    parameter int DISP_IDX  = 31,
    parameter     INIT_FILE = ""
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ADDR,
    output logic [31:0] MEM_INST,
    output logic        MEM_INST_ENB,
    input  logic [15:0] MEM_ADDR,
    output logic [31:0] MEM_LOAD,
    output logic        READ_ENABLE,
    input  logic [31:0] MEM_STORE,
    input  logic        MEM_WRITE_ENABLE,
    output logic        BUSY,
    output logic        ADDR_ERR,
    output logic [31:0] DISP_DATA
);

    localparam logic [31:0]      LIMIT  = 32'(4 * DEPTH);
    localparam logic [IDX_W-1:0] DISP_I = IDX_W'(DISP_IDX);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_RESP, S_WR} state_t;

    state_t state_q, state_d;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] addr_q;
    logic [15:0] maddr_q;
    logic        we_q;
    logic        fetch_pend_q, fetch_pend_d;
    logic        load_pend_q, load_pend_d;
    logic        store_pend_q, store_pend_d;
    logic [15:0] saddr_q;
    logic [31:0] sdata_q;
    logic [31:0] acc_addr_q, acc_addr_d;
    logic [31:0] acc_data_q, acc_data_d;
    logic        is_load_q, is_load_d;
    logic [31:0] inst_q, load_q, disp_q;
    logic        disp_upd_q;

    logic             fetch_set, load_set, store_set;
    logic             grant_fe, grant_ld, grant_st;
    logic             acc_oor;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      rdata;

    assign fetch_set = (ADDR != addr_q);
    assign load_set  = (MEM_ADDR != maddr_q);
    assign store_set = MEM_WRITE_ENABLE & ~we_q;

    assign acc_oor = (acc_addr_q >= LIMIT);
    assign acc_idx = acc_addr_q[IDX_W+1:2];
    assign rdata   = acc_oor ? 32'h0 : mem_q[acc_idx];

    // A grant samples the live input, so an event arriving on the granting edge is absorbed.
    always_comb begin
        state_d    = state_q;
        grant_fe   = 1'b0;
        grant_ld   = 1'b0;
        grant_st   = 1'b0;
        acc_addr_d = acc_addr_q;
        acc_data_d = acc_data_q;
        is_load_d  = is_load_q;
        case (state_q)
            S_IDLE: begin
                if (store_pend_q) begin
                    grant_st   = 1'b1;
                    state_d    = S_WR;
                    acc_addr_d = store_set ? {16'h0, MEM_ADDR} : {16'h0, saddr_q};
                    acc_data_d = store_set ? MEM_STORE : sdata_q;
                end else if (load_pend_q) begin
                    grant_ld   = 1'b1;
                    state_d    = S_RD;
                    acc_addr_d = {16'h0, MEM_ADDR};
                    is_load_d  = 1'b1;
                end else if (fetch_pend_q) begin
                    grant_fe   = 1'b1;
                    state_d    = S_RD;
                    acc_addr_d = ADDR;
                    is_load_d  = 1'b0;
                end
            end
            S_RD:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        fetch_pend_d = grant_fe ? 1'b0 : (fetch_pend_q | fetch_set);
        load_pend_d  = grant_ld ? 1'b0 : (load_pend_q | load_set);
        store_pend_d = grant_st ? 1'b0 : (store_pend_q | store_set);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0;
            maddr_q      <= 16'h0;
            we_q         <= 1'b0;
            fetch_pend_q <= 1'b1;
            load_pend_q  <= 1'b0;
            store_pend_q <= 1'b0;
            inst_q       <= 32'h0;
            load_q       <= 32'h0;
            disp_q       <= 32'h0;
            disp_upd_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= ADDR;
            maddr_q      <= MEM_ADDR;
            we_q         <= MEM_WRITE_ENABLE;
            fetch_pend_q <= fetch_pend_d;
            load_pend_q  <= load_pend_d;
            store_pend_q <= store_pend_d;
            if (state_q == S_RD) begin
                if (is_load_q) load_q <= rdata;
                else           inst_q <= rdata;
            end
            disp_upd_q <= (state_q == S_WR) && !acc_oor && (acc_idx == DISP_I);
            if (disp_upd_q) disp_q <= mem_q[DISP_I];
        end
    end

    // Datapath captures carry no reset; they are only consumed under FSM control.
    always_ff @(posedge CLK) begin
        if (store_set) begin
            saddr_q <= MEM_ADDR;
            sdata_q <= MEM_STORE;
        end
        acc_addr_q <= acc_addr_d;
        acc_data_q <= acc_data_d;
        is_load_q  <= is_load_d;
        if (state_q == S_WR && !acc_oor) mem_q[acc_idx] <= acc_data_q;
    end

    assign MEM_INST     = inst_q;
    assign MEM_LOAD     = load_q;
    assign DISP_DATA    = disp_q;
    assign MEM_INST_ENB = (state_q == S_RESP) && !is_load_q;
    assign READ_ENABLE  = (state_q == S_RESP) && is_load_q;
    assign ADDR_ERR     = ((state_q == S_RESP) || (state_q == S_WR)) && acc_oor;
    assign BUSY         = (state_q != S_IDLE) | fetch_pend_q | load_pend_q | store_pend_q;

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Directed scenario bench for cpu_mem_ctrl: reset fetch, store/load/display, priority,
// request coalescing, out-of-range accesses and reset during a response.
module tb_cpu_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] ADDR;
    logic [31:0] MEM_INST;
    logic        MEM_INST_ENB;
    logic [15:0] MEM_ADDR;
    logic [31:0] MEM_LOAD;
    logic        READ_ENABLE;
    logic [31:0] MEM_STORE;
    logic        MEM_WRITE_ENABLE;
    logic        BUSY;
    logic        ADDR_ERR;
    logic [31:0] DISP_DATA;

    int passed = 0;
    int total  = 0;

    cpu_mem_ctrl #(.DEPTH(32), .IDX_W(5), .DISP_IDX(31), .INIT_FILE("")) dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .MEM_INST(MEM_INST), .MEM_INST_ENB(MEM_INST_ENB),
        .MEM_ADDR(MEM_ADDR), .MEM_LOAD(MEM_LOAD), .READ_ENABLE(READ_ENABLE),
        .MEM_STORE(MEM_STORE), .MEM_WRITE_ENABLE(MEM_WRITE_ENABLE), .BUSY(BUSY),
        .ADDR_ERR(ADDR_ERR), .DISP_DATA(DISP_DATA)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle;
        bit idle = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!BUSY) begin idle = 1'b1; break; end
            step();
        end
        total++;
        if (!idle) $display("FAIL wait_idle: BUSY still %b, required 0 within 40 cycles", BUSY);
        else passed++;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [31:0] d);
        @(negedge CLK);
        MEM_ADDR = a; MEM_STORE = d; MEM_WRITE_ENABLE = 1'b1;
        step();
        @(negedge CLK);
        MEM_WRITE_ENABLE = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset;
        RST = 1'b1; ADDR = 32'h0; MEM_ADDR = 16'h0; MEM_STORE = 32'h0; MEM_WRITE_ENABLE = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (MEM_INST !== 32'h0) $display("FAIL rst_inst: got %h need 0", MEM_INST); else passed++;
        total++; if (MEM_LOAD !== 32'h0) $display("FAIL rst_load: got %h need 0", MEM_LOAD); else passed++;
        total++; if (DISP_DATA !== 32'h0) $display("FAIL rst_disp: got %h need 0", DISP_DATA); else passed++;
        total++; if ({MEM_INST_ENB, READ_ENABLE, ADDR_ERR} !== 3'b000)
            $display("FAIL rst_strobes: got %b need 000", {MEM_INST_ENB, READ_ENABLE, ADDR_ERR}); else passed++;
        total++; if (BUSY !== 1'b1) $display("FAIL rst_busy: got %b need 1", BUSY); else passed++;
        @(negedge CLK);
        RST = 1'b0;
        step();
        total++; if (MEM_INST_ENB !== 1'b0) $display("FAIL rst_enb_e1: got %b need 0", MEM_INST_ENB); else passed++;
        step();
        total++; if (MEM_INST_ENB !== 1'b1) $display("FAIL rst_enb_e2: got %b need 1", MEM_INST_ENB); else passed++;
        total++; if (READ_ENABLE !== 1'b0) $display("FAIL rst_re_e2: got %b need 0", READ_ENABLE); else passed++;
        step();
        total++; if (MEM_INST_ENB !== 1'b0) $display("FAIL rst_enb_e3: got %b need 0", MEM_INST_ENB); else passed++;
        total++; if (BUSY !== 1'b0) $display("FAIL rst_idle: BUSY got %b need 0", BUSY); else passed++;
    endtask

    task automatic test_store_load_disp;
        @(negedge CLK);
        MEM_ADDR = 16'h007C; MEM_STORE = 32'h20202031; MEM_WRITE_ENABLE = 1'b1;
        step();
        @(negedge CLK);
        MEM_WRITE_ENABLE = 1'b0;
        step();
        total++; if (ADDR_ERR !== 1'b0) $display("FAIL st_err: got %b need 0", ADDR_ERR); else passed++;
        total++; if (BUSY !== 1'b1) $display("FAIL st_busy: got %b need 1", BUSY); else passed++;
        step();
        total++; if (DISP_DATA !== 32'h0) $display("FAIL disp_early: got %h need 0", DISP_DATA); else passed++;
        step();
        total++; if (DISP_DATA !== 32'h20202031) $display("FAIL disp_upd: got %h need 20202031", DISP_DATA); else passed++;
        step();
        total++; if (READ_ENABLE !== 1'b1) $display("FAIL ld_re: got %b need 1", READ_ENABLE); else passed++;
        total++; if (MEM_LOAD !== 32'h20202031) $display("FAIL ld_data: got %h need 20202031", MEM_LOAD); else passed++;
        total++; if (MEM_INST_ENB !== 1'b0) $display("FAIL ld_enb: got %b need 0", MEM_INST_ENB); else passed++;
        step();
        total++; if (READ_ENABLE !== 1'b0) $display("FAIL ld_re_drop: got %b need 0", READ_ENABLE); else passed++;
        wait_idle();
    endtask

    task automatic test_reset_mid_resp;
        bit seen = 1'b0;
        int en_e = -1;
        int re_cnt = 0;
        logic [31:0] inst = 32'h0;
        @(negedge CLK);
        MEM_ADDR = 16'h007C;
        for (int i = 0; i < 10; i++) begin
            step();
            if (READ_ENABLE) begin seen = 1'b1; break; end
        end
        total++; if (!seen) $display("FAIL mid_resp_seen: READ_ENABLE got 0 need 1"); else passed++;
        #1;
        RST = 1'b1; MEM_ADDR = 16'h0;
        #1;
        total++; if (READ_ENABLE !== 1'b0) $display("FAIL mid_rst_re: got %b need 0", READ_ENABLE); else passed++;
        total++; if (MEM_LOAD !== 32'h0) $display("FAIL mid_rst_load: got %h need 0", MEM_LOAD); else passed++;
        total++; if (BUSY !== 1'b1) $display("FAIL mid_rst_busy: got %b need 1", BUSY); else passed++;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (MEM_INST_ENB && en_e < 0) begin en_e = i; inst = MEM_INST; end
            if (READ_ENABLE) re_cnt++;
        end
        total++; if (en_e != 2) $display("FAIL refetch_edge: got %0d need 2", en_e); else passed++;
        total++; if (inst !== 32'h01FFCF83) $display("FAIL refetch_data: got %h need 01ffcf83", inst); else passed++;
        total++; if (re_cnt != 0) $display("FAIL refetch_re: got %0d pulses need 0", re_cnt); else passed++;
        wait_idle();
    endtask

    task automatic test_same_edge;
        int re_e = -1;
        int en_e = -1;
        bit busy_low = 1'b0;
        logic [31:0] ld = 32'h0;
        logic [31:0] inst = 32'h0;
        @(negedge CLK);
        ADDR = 32'h4; MEM_ADDR = 16'h007C;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (en_e < 0 && !BUSY) busy_low = 1'b1;
            if (READ_ENABLE && re_e < 0) begin re_e = i; ld = MEM_LOAD; end
            if (MEM_INST_ENB && en_e < 0) begin en_e = i; inst = MEM_INST; end
        end
        total++; if (re_e != 3) $display("FAIL same_re_edge: got %0d need 3", re_e); else passed++;
        total++; if (en_e != 6) $display("FAIL same_enb_edge: got %0d need 6", en_e); else passed++;
        total++; if (ld !== 32'h20202031) $display("FAIL same_load: got %h need 20202031", ld); else passed++;
        total++; if (inst !== 32'h11111111) $display("FAIL same_inst: got %h need 11111111", inst); else passed++;
        total++; if (busy_low) $display("FAIL same_busy: BUSY got 0 need 1 until fetch response"); else passed++;
        wait_idle();
    endtask

    task automatic test_coalesce;
        int cnt = 0;
        logic [31:0] inst = 32'h0;
        @(negedge CLK);
        ADDR = 32'h8;
        step();
        @(negedge CLK);
        ADDR = 32'hC;
        for (int i = 0; i < 10; i++) begin
            step();
            if (MEM_INST_ENB) begin cnt++; inst = MEM_INST; end
        end
        total++; if (cnt != 1) $display("FAIL coalesce_cnt: got %0d pulses need 1", cnt); else passed++;
        total++; if (inst !== 32'h33333333) $display("FAIL coalesce_data: got %h need 33333333", inst); else passed++;
        wait_idle();
    endtask

    task automatic test_out_of_range;
        bit seen = 1'b0;
        int err_cnt = 0;
        int re_cnt = 0;
        logic err = 1'b0;
        logic [31:0] ld = 32'hFFFFFFFF;
        @(negedge CLK);
        MEM_ADDR = 16'h0080;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ADDR_ERR) err_cnt++;
            if (READ_ENABLE && !seen) begin seen = 1'b1; ld = MEM_LOAD; err = ADDR_ERR; end
        end
        total++; if (!seen) $display("FAIL oor_ld_re: READ_ENABLE got 0 need 1"); else passed++;
        total++; if (ld !== 32'h0) $display("FAIL oor_ld_data: got %h need 0", ld); else passed++;
        total++; if (err !== 1'b1) $display("FAIL oor_ld_err: got %b need 1", err); else passed++;
        total++; if (err_cnt != 1) $display("FAIL oor_ld_errcnt: got %0d need 1", err_cnt); else passed++;
        @(negedge CLK);
        MEM_STORE = 32'hDEADBEEF; MEM_WRITE_ENABLE = 1'b1;
        step();
        if (ADDR_ERR) err_cnt++;
        @(negedge CLK);
        MEM_WRITE_ENABLE = 1'b0;
        err_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ADDR_ERR) err_cnt++;
            if (READ_ENABLE) re_cnt++;
        end
        total++; if (err_cnt != 1) $display("FAIL oor_st_errcnt: got %0d need 1", err_cnt); else passed++;
        total++; if (re_cnt != 0) $display("FAIL oor_st_re: got %0d pulses need 0", re_cnt); else passed++;
        seen = 1'b0;
        @(negedge CLK);
        MEM_ADDR = 16'h0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (READ_ENABLE && !seen) begin seen = 1'b1; ld = MEM_LOAD; end
        end
        total++; if (ld !== 32'h01FFCF83) $display("FAIL oor_st_nowrite: word0 got %h need 01ffcf83", ld); else passed++;
        total++; if (DISP_DATA !== 32'h0) $display("FAIL oor_disp: got %h need 0", DISP_DATA); else passed++;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_store_load_disp();
        do_store(16'h0000, 32'h01FFCF83);
        do_store(16'h0004, 32'h11111111);
        do_store(16'h0008, 32'h22222222);
        do_store(16'h000C, 32'h33333333);
        test_reset_mid_resp();
        test_same_edge();
        test_coalesce();
        test_out_of_range();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
